// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix frame scheduler.
package matrix_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [1:0]  GNT_NONE = 2'b00;
  localparam logic [1:0]  GNT_P0   = 2'b01;
  localparam logic [1:0]  GNT_P1   = 2'b10;

  localparam logic [63:0] BLANK_FRAME = 64'h0;

  localparam int DEF_FRAME_CYCLES = 8;

endpackage

// File: rtl/matrix_frame_tick.sv
// Refresh-frame counter: wraps every FRAME_CYCLES clocks, flags the last cycle.
module matrix_frame_tick #(
  parameter int FRAME_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_frame_tick
);

  localparam int            CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] r_fcnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fcnt <= '0;
    end else if (r_fcnt == LAST) begin
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + CW'(1);
    end
  end

  assign o_frame_tick = (r_fcnt == LAST);

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Two-port priority frame scheduler for the 8x8 R/G matrix; swaps frames only on refresh boundaries.
// Optional per-port blinking is compiled in with MATRIX_BLINK_EN.
module matrix_frame_scheduler
  import matrix_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int DWELL_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [63:0]        pic_r0,
  input  logic [63:0]        pic_g0,
  input  logic [DWELL_W-1:0] dwell0,
`ifdef MATRIX_BLINK_EN
  input  logic               blink0,
  input  logic               blink1,
`endif
  output logic               ack0,
  input  logic               req1,
  input  logic [63:0]        pic_r1,
  input  logic [63:0]        pic_g1,
  input  logic [DWELL_W-1:0] dwell1,
  output logic               ack1,
  output logic [63:0]        pic_r,
  output logic [63:0]        pic_g,
  output logic [1:0]         grant,
  output logic               show_done,
  output logic               done_id
);

  logic               w_tick;
  logic               w_preempt;
  logic               w_decide;
  logic [DWELL_W-1:0] w_dwell0;
  logic [DWELL_W-1:0] w_dwell1;

  state_t             r_state;
  logic [DWELL_W-1:0] r_rem;
  logic [63:0]        r_pic_r;
  logic [63:0]        r_pic_g;
  logic [1:0]         r_grant;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_done;
  logic               r_done_id;
`ifdef MATRIX_BLINK_EN
  logic               r_blink;
  logic               r_odd;
`endif

  matrix_frame_tick #(
    .FRAME_CYCLES (FRAME_CYCLES)
  ) u_tick (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_frame_tick (w_tick)
  );

  assign w_dwell0  = (dwell0 == '0) ? DWELL_W'(1) : dwell0;
  assign w_dwell1  = (dwell1 == '0) ? DWELL_W'(1) : dwell1;
  assign w_preempt = (r_state == HOLD) && (r_grant == GNT_P1) && req0;
  assign w_decide  = w_tick && ((r_state == IDLE) || (r_rem == DWELL_W'(1)) || w_preempt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_pic_r   <= BLANK_FRAME;
      r_pic_g   <= BLANK_FRAME;
      r_grant   <= GNT_NONE;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
`ifdef MATRIX_BLINK_EN
      r_blink   <= 1'b0;
      r_odd     <= 1'b0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_done <= 1'b0;
      if (w_decide) begin
        // A HOLD decision that is not a preemption can only be the last frame.
        if ((r_state == HOLD) && !w_preempt) begin
          r_done    <= 1'b1;
          r_done_id <= (r_grant == GNT_P1);
        end
`ifdef MATRIX_BLINK_EN
        r_odd <= 1'b0;
`endif
        if (req0) begin
          r_state <= HOLD;
          r_ack0  <= 1'b1;
          r_pic_r <= pic_r0;
          r_pic_g <= pic_g0;
          r_grant <= GNT_P0;
          r_rem   <= w_dwell0;
`ifdef MATRIX_BLINK_EN
          r_blink <= blink0;
`endif
        end else if (req1) begin
          r_state <= HOLD;
          r_ack1  <= 1'b1;
          r_pic_r <= pic_r1;
          r_pic_g <= pic_g1;
          r_grant <= GNT_P1;
          r_rem   <= w_dwell1;
`ifdef MATRIX_BLINK_EN
          r_blink <= blink1;
`endif
        end else begin
          r_state <= IDLE;
          r_pic_r <= BLANK_FRAME;
          r_pic_g <= BLANK_FRAME;
          r_grant <= GNT_NONE;
          r_rem   <= '0;
`ifdef MATRIX_BLINK_EN
          r_blink <= 1'b0;
`endif
        end
      end else if (w_tick && (r_state == HOLD)) begin
        r_rem <= r_rem - DWELL_W'(1);
`ifdef MATRIX_BLINK_EN
        r_odd <= ~r_odd;
`endif
      end
    end
  end

`ifdef MATRIX_BLINK_EN
  // Odd frames of a blinking hold go dark; grant and dwell keep running.
  assign pic_r = (r_blink && r_odd) ? BLANK_FRAME : r_pic_r;
  assign pic_g = (r_blink && r_odd) ? BLANK_FRAME : r_pic_g;
`else
  assign pic_r = r_pic_r;
  assign pic_g = r_pic_g;
`endif

  assign grant     = r_grant;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign show_done = r_done;
  assign done_id   = r_done_id;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Directed self-checking bench for matrix_frame_scheduler.
module tb_matrix_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [63:0] pic_r0, pic_g0, pic_r1, pic_g1;
  logic [7:0]  dwell0, dwell1;
  logic        ack0, ack1;
  logic [63:0] pic_r, pic_g;
  logic [1:0]  grant;
  logic        show_done, done_id;
`ifdef MATRIX_BLINK_EN
  logic        blink0, blink1;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int base   = 0;

  always #5 clk = ~clk;

  matrix_frame_scheduler #(.FRAME_CYCLES(8), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .pic_r0    (pic_r0),
    .pic_g0    (pic_g0),
    .dwell0    (dwell0),
`ifdef MATRIX_BLINK_EN
    .blink0    (blink0),
    .blink1    (blink1),
`endif
    .ack0      (ack0),
    .req1      (req1),
    .pic_r1    (pic_r1),
    .pic_g1    (pic_g1),
    .dwell1    (dwell1),
    .ack1      (ack1),
    .pic_r     (pic_r),
    .pic_g     (pic_g),
    .grant     (grant),
    .show_done (show_done),
    .done_id   (done_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    pic_r0 = '0; pic_g0 = '0; pic_r1 = '0; pic_g1 = '0;
    dwell0 = '0; dwell1 = '0;
`ifdef MATRIX_BLINK_EN
    blink0 = 1'b0; blink1 = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    cyc = 0;

    // reset state
    chk("rst_pic_r", pic_r, 64'h0);
    chk("rst_pic_g", pic_g, 64'h0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_done", show_done, 1'b0);
    chk("rst_done_id", done_id, 1'b0);

    // port 1 alone, dwell 3
    req1 = 1'b1; dwell1 = 8'd3; pic_r1 = 64'hFF; pic_g1 = 64'h0F;
    wait_to(7);
    chk("t1_ack1_early", ack1, 1'b0);
    chk("t1_grant_early", grant, 2'b00);
    wait_to(8);
    chk("t1_ack1", ack1, 1'b1);
    chk("t1_grant", grant, 2'b10);
    chk("t1_pic_r", pic_r, 64'hFF);
    chk("t1_pic_g", pic_g, 64'h0F);
    req1 = 1'b0;
    wait_to(9);
    chk("t1_ack1_pulse", ack1, 1'b0);
    wait_to(31);
    chk("t1_pic_r_last", pic_r, 64'hFF);
    chk("t1_done_early", show_done, 1'b0);
    wait_to(32);
    chk("t1_done", show_done, 1'b1);
    chk("t1_done_id", done_id, 1'b1);
    chk("t1_blank", pic_r, 64'h0);
    chk("t1_gnt_none", grant, 2'b00);
    wait_to(33);
    chk("t1_done_pulse", show_done, 1'b0);

    // simultaneous requests: port 0 first, port 1 follows
    req0 = 1'b1; dwell0 = 8'd2; pic_r0 = 64'hA5A5; pic_g0 = 64'h5A5A;
    req1 = 1'b1; dwell1 = 8'd1; pic_r1 = 64'h1234; pic_g1 = 64'h4321;
    wait_to(40);
    chk("t2_ack0", ack0, 1'b1);
    chk("t2_ack1_none", ack1, 1'b0);
    chk("t2_grant", grant, 2'b01);
    chk("t2_pic_r", pic_r, 64'hA5A5);
    req0 = 1'b0;
    wait_to(55);
    chk("t2_hold_p0", grant, 2'b01);
    chk("t2_ack1_wait", ack1, 1'b0);
    wait_to(56);
    chk("t2_ack1", ack1, 1'b1);
    chk("t2_grant_p1", grant, 2'b10);
    chk("t2_done", show_done, 1'b1);
    chk("t2_done_id", done_id, 1'b0);
    chk("t2_pic_g1", pic_g, 64'h4321);
    req1 = 1'b0;
    wait_to(64);
    chk("t2_done_p1", show_done, 1'b1);
    chk("t2_done_id_p1", done_id, 1'b1);
    chk("t2_blank", grant, 2'b00);

    // preemption of port 1 by port 0
    req1 = 1'b1; dwell1 = 8'd5; pic_r1 = 64'hBEEF;
    wait_to(72);
    chk("t3_ack1", ack1, 1'b1);
    req1 = 1'b0;
    wait_to(77);
    req0 = 1'b1; dwell0 = 8'd1; pic_r0 = 64'hCAFE;
    wait_to(79);
    chk("t3_still_p1", grant, 2'b10);
    wait_to(80);
    chk("t3_ack0", ack0, 1'b1);
    chk("t3_grant", grant, 2'b01);
    chk("t3_no_done", show_done, 1'b0);
    chk("t3_pic_r", pic_r, 64'hCAFE);
    req0 = 1'b0;
    wait_to(88);
    chk("t3_done", show_done, 1'b1);
    chk("t3_done_id", done_id, 1'b0);
    chk("t3_blank", grant, 2'b00);

    // dwell 0 behaves as one frame
    req0 = 1'b1; dwell0 = 8'd0; pic_r0 = 64'h77;
    wait_to(96);
    chk("t4_ack0", ack0, 1'b1);
    req0 = 1'b0;
    wait_to(103);
    chk("t4_hold", pic_r, 64'h77);
    chk("t4_done_early", show_done, 1'b0);
    wait_to(104);
    chk("t4_done", show_done, 1'b1);
    chk("t4_blank", pic_r, 64'h0);

    // reset mid-hold, pending request re-wins after release
    req1 = 1'b1; dwell1 = 8'd4; pic_r1 = 64'h99;
    wait_to(112);
    chk("t5_ack1", ack1, 1'b1);
    req1 = 1'b0;
    req0 = 1'b1; dwell0 = 8'd1; pic_r0 = 64'h55;
    wait_to(116);
    rst = 1'b1;
    step();
    chk("t5_rst_pic", pic_r, 64'h0);
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_ack0", ack0, 1'b0);
    rst = 1'b0;
    base = cyc;
    wait_to(base + 7);
    chk("t5_ack0_early", ack0, 1'b0);
    wait_to(base + 8);
    chk("t5_ack0", ack0, 1'b1);
    chk("t5_grant", grant, 2'b01);
    req0 = 1'b0;
    wait_to(base + 16);
    chk("t5_done", show_done, 1'b1);
    chk("t5_done_id", done_id, 1'b0);

`ifdef MATRIX_BLINK_EN
    // blinking alarm: visible, blank, visible, blank
    base = cyc;
    req0 = 1'b1; dwell0 = 8'd4; pic_r0 = 64'hF0F0; pic_g0 = 64'h0F0F; blink0 = 1'b1;
    wait_to(base + 8);
    chk("t6_ack0", ack0, 1'b1);
    chk("t6_f0", pic_r, 64'hF0F0);
    req0 = 1'b0;
    wait_to(base + 16);
    chk("t6_f1_r", pic_r, 64'h0);
    chk("t6_f1_g", pic_g, 64'h0);
    chk("t6_f1_grant", grant, 2'b01);
    wait_to(base + 24);
    chk("t6_f2", pic_g, 64'h0F0F);
    wait_to(base + 39);
    chk("t6_f3", pic_r, 64'h0);
    wait_to(base + 40);
    chk("t6_done", show_done, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
